// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// operand_fetch: 16-entry RF, decode, one registered issue slot toward the ALU.
// Optional: OPERAND_FETCH_WB_BYPASS_EN forwards write-back data into operands.
// Revision: 1.0
// ============================================================================
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int OP_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W+3*REG_AW-1:0] instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          opcode,
    output logic [DATA_W-1:0]        data0,
    output logic [DATA_W-1:0]        data1,
    output logic [REG_AW-1:0]        dest,
    input  logic                     wb_en,
    input  logic [REG_AW-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data
);

    localparam int c_NUM_REGS = 2**REG_AW;

    logic [DATA_W-1:0] r_rf [c_NUM_REGS];

    logic              r_out_valid;
    logic [OP_W-1:0]   r_opcode;
    logic [REG_AW-1:0] r_dest;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;

    logic [OP_W-1:0]   w_opcode;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;

    assign {w_opcode, w_rd, w_rs1, w_rs2} = instr;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        w_rd0 = r_rf[w_rs1];
        w_rd1 = r_rf[w_rs2];
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (wb_en && (wb_addr == w_rs1)) begin
            w_rd0 = wb_data;
        end
        if (wb_en && (wb_addr == w_rs2)) begin
            w_rd1 = wb_data;
        end
`endif
    end

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // Source tags of the held operands, used to refresh them from write-back.
    logic [REG_AW-1:0] r_tag1;
    logic [REG_AW-1:0] r_tag2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else if (w_accept) begin
            r_tag1 <= w_rs1;
            r_tag2 <= w_rs2;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_dest      <= '0;
            r_data0     <= '0;
            r_data1     <= '0;
        end else begin
`ifdef OPERAND_FETCH_WB_BYPASS_EN
            // A held slot can never accept, so this never races the load below.
            if (r_out_valid && !out_ready && wb_en) begin
                if (wb_addr == r_tag1) begin
                    r_data0 <= wb_data;
                end
                if (wb_addr == r_tag2) begin
                    r_data1 <= wb_data;
                end
            end
`endif
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_opcode    <= w_opcode;
                r_dest      <= w_rd;
                r_data0     <= w_rd0;
                r_data1     <= w_rd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign opcode    = r_opcode;
    assign dest      = r_dest;
    assign data0     = r_data0;
    assign data1     = r_data1;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// tb_operand_fetch: directed scenarios plus randomized traffic vs. a
// transaction-level reference model of the fetch stage.
// Revision: 1.0
// ============================================================================
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [3:0]  dest;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_rf [16];
    logic        m_valid;
    logic [3:0]  m_op, m_dest, m_rs1, m_rs2;
    logic [31:0] m_d0, m_d1;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(32), .REG_AW(4), .OP_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .data0     (data0),
        .data1     (data1),
        .dest      (dest),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    // Apply one clock edge to both the model and the DUT using current inputs.
    task automatic tick();
        logic        acc;
        logic [31:0] r0, r1;
        logic [3:0]  s1, s2;
        s1  = instr[7:4];
        s2  = instr[3:0];
        acc = in_valid && (!m_valid || out_ready);
        r0  = m_rf[s1];
        r1  = m_rf[s2];
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (wb_en && wb_addr == s1) r0 = wb_data;
        if (wb_en && wb_addr == s2) r1 = wb_data;
`endif
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
            m_valid = 1'b0; m_op = 4'd0; m_dest = 4'd0;
            m_d0 = 32'd0; m_d1 = 32'd0; m_rs1 = 4'd0; m_rs2 = 4'd0;
        end else begin
`ifdef OPERAND_FETCH_WB_BYPASS_EN
            if (m_valid && !out_ready && wb_en) begin
                if (wb_addr == m_rs1) m_d0 = wb_data;
                if (wb_addr == m_rs2) m_d1 = wb_data;
            end
`endif
            if (acc) begin
                m_valid = 1'b1; m_op = instr[15:12]; m_dest = instr[11:8];
                m_d0 = r0; m_d1 = r1; m_rs1 = s1; m_rs2 = s2;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en) m_rf[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; out_ready = 1'b0; instr = 16'd0;
        wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
    endtask

    task automatic rf_write(input logic [3:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        n_vec++;
        if ({out_valid, opcode, dest, data0, data1} !== 73'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, opcode, dest, data0, data1});
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        rf_write(4'd3, 32'd35);
        rf_write(4'd4, 32'd12);
        instr = {4'h0, 4'd5, 4'd3, 4'd4};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, opcode, dest, data0, data1} !== {1'b1, 4'h0, 4'd5, 32'd35, 32'd12}) begin
            n_err++;
            $display("FAIL basic_issue: got %h want %h", {out_valid, opcode, dest, data0, data1},
                     {1'b1, 4'h0, 4'd5, 32'd35, 32'd12});
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || data0 !== 32'd35) begin
            n_err++;
            $display("FAIL basic_drain: got valid=%b data0=%0d want valid=0 data0=35", out_valid, data0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  s1 [3];
        logic [3:0]  s2 [3];
        logic [31:0] e0 [3];
        logic [31:0] e1 [3];
        s1 = '{4'd1, 4'd2, 4'd1}; s2 = '{4'd2, 4'd1, 4'd1};
        e0 = '{32'd50, 32'd10, 32'd50}; e1 = '{32'd10, 32'd50, 32'd50};
        rf_write(4'd1, 32'd50);
        rf_write(4'd2, 32'd10);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = {4'(k + 1), 4'(k + 7), s1[k], s2[k]};
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready);
            end
            tick();
            n_vec++;
            if ({out_valid, data0, data1} !== {1'b1, e0[k], e1[k]}) begin
                n_err++;
                $display("FAIL b2b_issue[%0d]: got v=%b %0d,%0d want v=1 %0d,%0d",
                         k, out_valid, data0, data1, e0[k], e1[k]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [72:0] snap;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = {4'h3, 4'd2, 4'd3, 4'd4};
        tick();
        snap  = {out_valid, opcode, dest, data0, data1};
        instr = {4'h9, 4'd8, 4'd1, 4'd2};
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (in_ready !== 1'b0 || {out_valid, opcode, dest, data0, data1} !== snap) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got rdy=%b %h want rdy=0 %h", k, in_ready,
                         {out_valid, opcode, dest, data0, data1}, snap);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, opcode, dest, data0, data1} !== {1'b1, 4'h9, 4'd8, 32'd50, 32'd10}) begin
            n_err++;
            $display("FAIL stall_second: got %h want %h", {out_valid, opcode, dest, data0, data1},
                     {1'b1, 4'h9, 4'd8, 32'd50, 32'd10});
        end
        tick();
    endtask

    task automatic test_bypass_accept();
        logic [31:0] want;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        want = 32'h0000_00AA;
`else
        want = 32'd7;
`endif
        rf_write(4'd6, 32'd7);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = {4'h1, 4'd2, 4'd6, 4'd0};
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h0000_00AA;
        tick();
        wb_en = 1'b0;
        n_vec++;
        if (data0 !== want || data0 !== m_d0) begin
            n_err++;
            $display("FAIL bypass_accept: got %h want %h", data0, want);
        end
        instr = {4'h1, 4'd2, 4'd6, 4'd6};
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (data0 !== 32'hAA || data1 !== 32'hAA) begin
            n_err++;
            $display("FAIL bypass_rf_after: got %h,%h want aa,aa", data0, data1);
        end
        tick();
    endtask

    task automatic test_bypass_held();
        logic [31:0] want;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        want = 32'd21;
`else
        want = 32'd5;
`endif
        rf_write(4'd9, 32'd5);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = {4'h2, 4'd1, 4'd3, 4'd9};
        tick();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'd21;
        tick();
        wb_en = 1'b0;
        tick();
        n_vec++;
        if (data1 !== want || out_valid !== 1'b1 || data0 !== 32'd35) begin
            n_err++;
            $display("FAIL bypass_held: got v=%b d0=%0d d1=%0d want v=1 d0=35 d1=%0d",
                     out_valid, data0, data1, want);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = {4'h5, 4'd4, 4'd3, 4'd1};
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'hDEAD_BEEF;
        tick();
        reset_n = 1'b1;
        wb_en   = 1'b0;
        n_vec++;
        if ({out_valid, data0, data1} !== 65'd0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b %h,%h want 0", out_valid, data0, data1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr = {4'h0, 4'd0, 4'(2 * k), 4'(2 * k + 1)};
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || data0 !== 32'd0 || data1 !== 32'd0) begin
                n_err++;
                $display("FAIL reset_rf_read[%0d]: got v=%b %h,%h want v=1 0,0", k, out_valid, data0, data1);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = 16'($urandom());
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_addr   = 4'($urandom());
            wb_data   = $urandom();
            #1;
            n_vec++;
            if (in_ready !== (!m_valid || out_ready)) begin
                n_err++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", k, in_ready, (!m_valid || out_ready));
            end
            tick();
            n_vec++;
            if ({out_valid, opcode, dest, data0, data1} !== {m_valid, m_op, m_dest, m_d0, m_d1}) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got %h want %h", k, {out_valid, opcode, dest, data0, data1},
                         {m_valid, m_op, m_dest, m_d0, m_d1});
            end
        end
        reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_bypass_accept();
        test_bypass_held();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
